upg_loader_ctrl: RTL and testbench
==================================

Name: upg_loader_ctrl

Overview:
Sequences the serial program-upload path into the instruction RAM. Takes a byte stream from the UART receiver and parses a length-prefixed frame. Assembles little-endian 32-bit words and drives the instruction-RAM upload port: upg_rst, upg_wen, upg_addr, upg_data and upg_done. Holds the fetch unit in upload mode until the image is complete.

Parameters:
ADDR_W, 14, word-address width of the instruction RAM; max image = 2^ADDR_W words
TIMEOUT, 100000, idle clk cycles allowed between bytes mid-frame before abort
TO_W, 17, timeout counter width (must hold TIMEOUT)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-high
start_i  input  1  single-cycle pulse: begin or restart an upload session
rx_valid_i  input  1  single-cycle strobe, one received byte; no backpressure
rx_data_i  input  8  received byte, valid with rx_valid_i
upg_rst_o  output  1  1 = CPU normal mode; 0 = upload in progress
upg_wen_o  output  1  one-cycle instruction-RAM write strobe
upg_addr_o  output  ADDR_W  word address of the write
upg_data_o  output  32  word to write
upg_done_o  output  1  image complete; held until next start_i
busy_o  output  1  session active (LEN0/LEN1/DATA)
err_o  output  1  session aborted; held until next start_i
word_cnt_o  output  ADDR_W+1  words written this session

Behaviour:
- Reset (rst_n=1, async):
  - state=IDLE; upg_rst_o=1.
  - upg_wen_o, upg_done_o, busy_o, err_o = 0.
  - upg_addr_o, upg_data_o, word_cnt_o = 0.
- States: IDLE, LEN0, LEN1, DATA, DONE, ERR. All outputs are registered.
- Frame format:
  - 2-byte word count, low byte first.
  - Then count×4 data bytes, each word little-endian (first byte = bits[7:0]).
- start_i, accepted in any state:
  - Next state LEN0; clears done, err, word_cnt, byte index, timeout counter and assembly register.
  - Has priority over a simultaneous rx_valid_i; that byte is discarded and no write is issued from it.
- IDLE: rx_valid_i ignored.
- LEN0:
  - Byte → len[7:0], go to LEN1.
  - Waits indefinitely; timeout inactive.
- LEN1:
  - Byte → len[15:8].
  - If len==0 → DONE.
  - If len > 2^ADDR_W → ERR.
  - Otherwise → DATA.
- DATA:
  - byte_idx 0..3 selects the byte lane. On byte_idx==3 the word is complete.
  - In the next cycle: upg_wen_o=1 for exactly one cycle, upg_addr_o = word_cnt (pre-increment), upg_data_o = assembled word.
  - word_cnt increments in that same cycle.
  - When word_cnt reaches len after the final write, go to DONE. upg_done_o=1 in the cycle after the last wen pulse.
- Write latency: 1 clk from the rx_valid_i of the 4th byte to upg_wen_o.
  - Back-to-back bytes on consecutive cycles are supported. Minimum spacing is 1 cycle; words complete at most every 4 cycles.
- Timeout (LEN1, DATA only):
  - Counter increments each cycle without rx_valid_i and clears on rx_valid_i.
  - When counter == TIMEOUT-1 without a byte → ERR.
- DONE: upg_done_o=1, upg_rst_o=1, busy_o=0. rx_valid_i ignored.
- ERR:
  - err_o=1, upg_done_o=0, busy_o=0.
  - upg_rst_o stays 0, so the CPU is never released onto a partial image. Only start_i or reset exits.
- upg_rst_o=0 in LEN0/LEN1/DATA/ERR; 1 in IDLE/DONE.
- Extra bytes after the last word (in DONE) are ignored.
- upg_addr_o and upg_data_o hold their last value when upg_wen_o=0.
- Reset mid-operation: immediate return to reset values. No write pulse is emitted after reset asserts.

Test Plan:
- Reset, then start_i; send 02 00 | 13 00 00 00 | 93 00 10 00 → wen pulses: addr 0 data 0x00000013, addr 1 data 0x00100093. upg_done_o=1 one cycle after the 2nd wen; upg_rst_o 0→1; word_cnt_o=2.
- start_i; send 00 00 → DONE with no wen; done=1, upg_rst_o=1.
- start_i; send 01 40 (len=16385) → ERR, err_o=1, upg_rst_o=0, no wen. Repeat with len=16384 and verify the last write lands at addr 0x3FFF.
- TIMEOUT=16: start_i; send 01 00 AA BB, then idle 16 cycles → err_o=1, no wen. Then start_i plus a valid 1-word frame → done=1, err_o=0.
- start_i; send 02 00 and 3 bytes of word 0; pulse start_i in the same cycle as the 4th byte → no wen. State LEN0, word_cnt_o=0; a fresh 1-word frame writes addr 0.
- Bytes on consecutive cycles for a 3-word frame, with rst_n pulsed during word 2 → all outputs return to reset values immediately; no further wen.

Source files
------------

// File: rtl/upg_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : upg_loader_ctrl
// Description : Parses a length-prefixed UART byte frame into little-endian
//               words and drives the instruction-RAM upload port.
// Revision    : 1.0 - initial release
// ============================================================================
module upg_loader_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 100000,
  parameter int TO_W    = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              upg_rst_o,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_addr_o,
  output logic [31:0]       upg_data_o,
  output logic              upg_done_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [TO_W-1:0]   c_TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   c_TO_ONE    = TO_W'(1);
  localparam logic [ADDR_W:0]   c_CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [16:0]       c_MAX_WORDS = 17'(1 << ADDR_W);

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_len, w_len_nxt;
  logic [1:0]          r_byte_idx, w_byte_idx_nxt;
  logic [31:0]         r_asm, w_asm_nxt;
  logic [TO_W-1:0]     r_to_cnt, w_to_nxt;
  logic [ADDR_W:0]     r_word_cnt, w_word_cnt_nxt;
  logic                r_wen, w_wen_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [31:0]         r_data, w_data_nxt;
  logic                r_upg_rst, r_done, r_busy, r_err;

  logic [15:0]         w_len_full;
  logic                w_words_done;
  logic                w_to_expired;

  assign w_len_full   = {rx_data_i, r_len[7:0]};
  assign w_words_done = (32'(r_word_cnt) == 32'(r_len));
  assign w_to_expired = (r_to_cnt == c_TO_LAST);

  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_byte_idx_nxt = r_byte_idx;
    w_asm_nxt      = r_asm;
    w_to_nxt       = r_to_cnt;
    w_word_cnt_nxt = r_word_cnt;
    w_wen_nxt      = 1'b0;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;

    // A restart wins over any byte arriving in the same cycle.
    if (start_i) begin
      w_state_nxt    = S_LEN0;
      w_byte_idx_nxt = 2'd0;
      w_asm_nxt      = 32'd0;
      w_to_nxt       = '0;
      w_word_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_LEN0: begin
          if (rx_valid_i) begin
            w_len_nxt[7:0] = rx_data_i;
            w_to_nxt       = '0;
            w_state_nxt    = S_LEN1;
          end
        end
        S_LEN1: begin
          if (rx_valid_i) begin
            w_len_nxt      = w_len_full;
            w_to_nxt       = '0;
            w_byte_idx_nxt = 2'd0;
            if (w_len_full == 16'd0)
              w_state_nxt = S_DONE;
            else if ({1'b0, w_len_full} > c_MAX_WORDS)
              w_state_nxt = S_ERR;
            else
              w_state_nxt = S_DATA;
          end else if (w_to_expired) begin
            w_state_nxt = S_ERR;
          end else begin
            w_to_nxt = r_to_cnt + c_TO_ONE;
          end
        end
        S_DATA: begin
          // Final write was issued last cycle; done follows one cycle later.
          if (w_words_done) begin
            w_state_nxt = S_DONE;
          end else if (rx_valid_i) begin
            w_to_nxt                          = '0;
            w_asm_nxt[{r_byte_idx, 3'b000} +: 8] = rx_data_i;
            w_byte_idx_nxt                    = r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              w_wen_nxt      = 1'b1;
              w_addr_nxt     = r_word_cnt[ADDR_W-1:0];
              w_data_nxt     = {rx_data_i, r_asm[23:0]};
              w_word_cnt_nxt = r_word_cnt + c_CNT_ONE;
            end
          end else if (w_to_expired) begin
            w_state_nxt = S_ERR;
          end else begin
            w_to_nxt = r_to_cnt + c_TO_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= 16'd0;
      r_byte_idx <= 2'd0;
      r_asm      <= 32'd0;
      r_to_cnt   <= '0;
      r_word_cnt <= '0;
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_data     <= 32'd0;
      r_upg_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_asm      <= w_asm_nxt;
      r_to_cnt   <= w_to_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_wen      <= w_wen_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      // CPU is released only from IDLE or a complete image, never from ERR.
      r_upg_rst  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
      r_done     <= (w_state_nxt == S_DONE);
      r_busy     <= (w_state_nxt == S_LEN0) || (w_state_nxt == S_LEN1) ||
                    (w_state_nxt == S_DATA);
      r_err      <= (w_state_nxt == S_ERR);
    end
  end

  assign upg_rst_o  = r_upg_rst;
  assign upg_wen_o  = r_wen;
  assign upg_addr_o = r_addr;
  assign upg_data_o = r_data;
  assign upg_done_o = r_done;
  assign busy_o     = r_busy;
  assign err_o      = r_err;
  assign word_cnt_o = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_upg_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_upg_loader_ctrl
// Description : Vector table, directed corner sequences and random sessions
//               checked against a byte-queue frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_upg_loader_ctrl;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int TO_W    = 5;
  localparam int MAXW    = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              start_i;
  logic              rx_valid_i;
  logic [7:0]        rx_data_i;
  logic              upg_rst_o;
  logic              upg_wen_o;
  logic [ADDR_W-1:0] upg_addr_o;
  logic [31:0]       upg_data_o;
  logic              upg_done_o;
  logic              busy_o;
  logic              err_o;
  logic [ADDR_W:0]   word_cnt_o;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  upg_loader_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .upg_rst_o  (upg_rst_o),
    .upg_wen_o  (upg_wen_o),
    .upg_addr_o (upg_addr_o),
    .upg_data_o (upg_data_o),
    .upg_done_o (upg_done_o),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .word_cnt_o (word_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame model: session bytes kept in a queue, outputs derived from its size.
  logic [7:0]        m_q[$];
  bit                m_started, m_err, m_complete, m_wen;
  int                m_age, m_idle, m_len;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_data;

  task automatic model_reset();
    m_q.delete();
    m_started = 0; m_err = 0; m_complete = 0; m_wen = 0;
    m_age = 0; m_idle = 0; m_len = 0;
    m_addr = '0; m_data = 32'd0;
  endtask

  task automatic model_step(input logic s, input logic rv, input logic [7:0] d, input logic rst);
    int n;
    m_wen = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (s) begin
      m_q.delete();
      m_started = 1; m_err = 0; m_complete = 0; m_age = 0; m_idle = 0;
      return;
    end
    if (!m_started || m_err) return;
    if (m_complete) begin
      if (m_age < 2) m_age++;
      return;
    end
    if (rv) begin
      m_q.push_back(d);
      m_idle = 0;
      n = m_q.size();
      if (n == 2) begin
        m_len = int'(m_q[0]) + 256 * int'(m_q[1]);
        if (m_len == 0) begin
          m_complete = 1; m_age = 1;
        end else if (m_len > MAXW) begin
          m_err = 1;
        end
      end else if (n > 2 && (n - 2) % 4 == 0) begin
        m_wen  = 1;
        m_addr = ADDR_W'((n - 2) / 4 - 1);
        m_data = {m_q[n-1], m_q[n-2], m_q[n-3], m_q[n-4]};
        if ((n - 2) / 4 == m_len) begin
          m_complete = 1; m_age = 0;
        end
      end
    end else if (m_q.size() >= 1) begin
      if (m_idle == TIMEOUT - 1) m_err = 1;
      else m_idle++;
    end
  endtask

  task automatic cmp_model();
    logic e_done, e_busy, e_rst;
    logic [ADDR_W:0] e_cnt;
    int sz;
    sz     = m_q.size();
    e_cnt  = (sz >= 2) ? (ADDR_W+1)'((sz - 2) / 4) : '0;
    e_done = m_started && !m_err && m_complete && (m_age >= 1);
    e_busy = m_started && !m_err && !(m_complete && (m_age >= 1));
    e_rst  = !m_started || e_done;
    vec_cnt++;
    if (upg_wen_o !== m_wen || upg_addr_o !== m_addr || upg_data_o !== m_data ||
        upg_done_o !== e_done || err_o !== m_err || busy_o !== e_busy ||
        upg_rst_o !== e_rst || word_cnt_o !== e_cnt) begin
      miss_cnt++;
      $display("FAIL model @%0t wen/addr/data/done/err/busy/rst/cnt got %b/%h/%h/%b/%b/%b/%b/%0d want %b/%h/%h/%b/%b/%b/%b/%0d",
               $time, upg_wen_o, upg_addr_o, upg_data_o, upg_done_o, err_o, busy_o, upg_rst_o, word_cnt_o,
               m_wen, m_addr, m_data, e_done, m_err, e_busy, e_rst, e_cnt);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input logic s, input logic rv, input logic [7:0] d);
    start_i = s; rx_valid_i = rv; rx_data_i = d;
    @(posedge clk);
    model_step(s, rv, d, rst_n);
    #1;
    cmp_model();
    start_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    tick(1'b0, 1'b1, d);
    repeat (gap) tick(1'b0, 1'b0, 8'h00);
  endtask

  function automatic int rgap();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 2) return TIMEOUT + int'($urandom_range(0, 3));
    if (r < 5) return TIMEOUT - 1;
    return int'($urandom_range(0, 3));
  endfunction

  typedef struct packed {
    logic              s, rv;
    logic [7:0]        d;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              done, err, busy, ur;
    logic [ADDR_W:0]   cnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 9'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 9'd0};
    tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 9'd0};
    tbl[3]  = '{1'b0, 1'b1, 8'h13, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 9'd0};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 9'd0};
    tbl[5]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 9'd0};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 32'h00000013, 1'b0, 1'b0, 1'b1, 1'b0, 9'd1};
    tbl[7]  = '{1'b0, 1'b1, 8'h93, 1'b0, 8'h00, 32'h00000013, 1'b0, 1'b0, 1'b1, 1'b0, 9'd1};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 32'h00000013, 1'b0, 1'b0, 1'b1, 1'b0, 9'd1};
    tbl[9]  = '{1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 32'h00000013, 1'b0, 1'b0, 1'b1, 1'b0, 9'd1};
    tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h01, 32'h00100093, 1'b0, 1'b0, 1'b1, 1'b0, 9'd2};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 32'h00100093, 1'b1, 1'b0, 1'b0, 1'b1, 9'd2};
    tbl[12] = '{1'b0, 1'b1, 8'hAA, 1'b0, 8'h01, 32'h00100093, 1'b1, 1'b0, 1'b0, 1'b1, 9'd2};
    tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 32'h00100093, 1'b0, 1'b0, 1'b1, 1'b0, 9'd0};
    tbl[14] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h01, 32'h00100093, 1'b0, 1'b0, 1'b1, 1'b0, 9'd0};
    tbl[15] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h01, 32'h00100093, 1'b1, 1'b0, 1'b0, 1'b1, 9'd0};

    model_reset();
    rst_n = 1'b1; start_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    repeat (3) tick(1'b0, 1'b0, 8'h00);
    check("reset_upg_rst", 32'(upg_rst_o), 32'd1);
    rst_n = 1'b0;
    tick(1'b0, 1'b1, 8'h55);
    check("idle_ignores_rx", 32'(busy_o), 32'd0);

    // Two-word image, then an empty frame.
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].s, tbl[i].rv, tbl[i].d);
      vec_cnt++;
      if ({upg_wen_o, upg_addr_o, upg_data_o, upg_done_o, err_o, busy_o, upg_rst_o, word_cnt_o} !==
          {tbl[i].wen, tbl[i].addr, tbl[i].data, tbl[i].done, tbl[i].err, tbl[i].busy, tbl[i].ur, tbl[i].cnt}) begin
        miss_cnt++;
        $display("FAIL tbl[%0d] wen/addr/data/done/err/busy/rst/cnt got %b/%h/%h/%b/%b/%b/%b/%0d want %b/%h/%h/%b/%b/%b/%b/%0d",
                 i, upg_wen_o, upg_addr_o, upg_data_o, upg_done_o, err_o, busy_o, upg_rst_o, word_cnt_o,
                 tbl[i].wen, tbl[i].addr, tbl[i].data, tbl[i].done, tbl[i].err, tbl[i].busy, tbl[i].ur, tbl[i].cnt);
      end
    end

    // Oversized image: one word beyond capacity.
    tick(1'b1, 1'b0, 8'h00);
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    check("oversize_err", 32'(err_o), 32'd1);
    check("oversize_rst", 32'(upg_rst_o), 32'd0);
    repeat (4) send_byte(8'hC3, 0);
    check("oversize_no_wen", 32'(upg_wen_o), 32'd0);

    // Full-capacity image: last write lands on the top address.
    tick(1'b1, 1'b0, 8'h00);
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    for (int i = 0; i < 4 * MAXW; i++) send_byte(8'(i * 7 + 3), 0);
    check("full_last_wen", 32'(upg_wen_o), 32'd1);
    check("full_last_addr", 32'(upg_addr_o), 32'(MAXW - 1));
    check("full_cnt", 32'(word_cnt_o), 32'(MAXW));
    tick(1'b0, 1'b0, 8'h00);
    check("full_done", 32'(upg_done_o), 32'd1);

    // Inter-byte timeout, then recovery with a fresh frame.
    tick(1'b1, 1'b0, 8'h00);
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    repeat (TIMEOUT - 1) tick(1'b0, 1'b0, 8'h00);
    check("timeout_edge_minus1", 32'(err_o), 32'd0);
    tick(1'b0, 1'b0, 8'h00);
    check("timeout_err", 32'(err_o), 32'd1);
    check("timeout_rst", 32'(upg_rst_o), 32'd0);
    tick(1'b1, 1'b0, 8'h00);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
    check("recover_data", upg_data_o, 32'hDEADBEEF);
    tick(1'b0, 1'b0, 8'h00);
    check("recover_done", 32'(upg_done_o), 32'd1);
    check("recover_err", 32'(err_o), 32'd0);

    // start_i collides with the 4th byte of a word.
    tick(1'b1, 1'b0, 8'h00);
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    tick(1'b1, 1'b1, 8'h44);
    check("collide_no_wen", 32'(upg_wen_o), 32'd0);
    check("collide_cnt", 32'(word_cnt_o), 32'd0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0); send_byte(8'h77, 0); send_byte(8'h88, 0);
    check("collide_addr", 32'(upg_addr_o), 32'd0);
    check("collide_data", upg_data_o, 32'h88776655);

    // Asynchronous reset in the middle of word 2.
    tick(1'b1, 1'b0, 8'h00);
    send_byte(8'h03, 0); send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h20 + i), 0);
    #2 rst_n = 1'b1;
    #1;
    check("arst_wen", 32'(upg_wen_o), 32'd0);
    check("arst_state", {28'd0, upg_rst_o, busy_o, upg_done_o, err_o}, 32'h8);
    check("arst_cnt", 32'(word_cnt_o), 32'd0);
    check("arst_addr_data", upg_data_o | 32'(upg_addr_o), 32'd0);
    model_reset();
    tick(1'b0, 1'b1, 8'h26);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_byte(8'(8'h27 + i), 0);
      check("arst_no_wen", 32'(upg_wen_o), 32'd0);
    end

    // Random sessions with random spacing, restarts and extra bytes.
    for (int s = 0; s < 40; s++) begin
      int len, nb;
      tick(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
      len = ($urandom_range(0, 9) == 0) ? MAXW + 1 + int'($urandom_range(0, 40))
                                        : int'($urandom_range(0, 5));
      send_byte(len[7:0], rgap());
      send_byte(len[15:8], rgap());
      nb = (len > MAXW) ? 8 : 4 * len;
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 79) == 0) begin
          tick(1'b1, 1'b1, 8'($urandom));
          break;
        end
        send_byte(8'($urandom), rgap());
      end
      repeat ($urandom_range(1, 4)) tick(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
`default_nettype wire
